// File: rtl/j_sync6_load.sv
// j_sync6_load: toggle-handshake feeder for the Jerry 6-bit load-enabled
// holding register. A request toggle from a foreign domain is synchronised
// and the asynchronous data is filtered for stability. The block then issues
// a one-cycle load strobe with the data and answers with an acknowledge toggle.
module j_sync6_load #(
  parameter int STABLE_CYCLES = 2  // identical samples required, 1..15
) (
  input  logic       sys_clk,
  input  logic       resetl,
  input  logic       src_req,
  input  logic [0:5] src_d,
  input  logic       clr,
  output logic       src_ack,
  output logic [0:5] d,
  output logic       ld,
  output logic       busy,
  output logic       overrun,
  output logic [3:0] glitch
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_LOAD   = 2'd2
  } state_t;

  // Count value at which the next matching sample completes the stability window.
  localparam logic [3:0] CNT_LAST = 4'(STABLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic       req_s1_q, req_s1_d;
  logic       req_s2_q, req_s2_d;
  logic       req_s3_q, req_s3_d;
  logic       pending_q, pending_d;
  logic [0:5] sample_q, sample_d;
  logic [3:0] cnt_q, cnt_d;
  logic [0:5] d_q, d_d;
  logic       ld_q, ld_d;
  logic       src_ack_q, src_ack_d;
  logic       busy_q, busy_d;
  logic       overrun_q, overrun_d;
  logic [3:0] glitch_q, glitch_d;

  logic       ev_s;
  logic       glitch_inc_s;
  logic       overrun_set_s;

  // Next-state, datapath and flag computation for the whole transfer engine.
  always_comb begin
    state_d       = state_q;
    req_s1_d      = src_req;
    req_s2_d      = req_s1_q;
    req_s3_d      = req_s2_q;
    pending_d     = pending_q;
    sample_d      = sample_q;
    cnt_d         = cnt_q;
    d_d           = d_q;
    ld_d          = 1'b0;
    src_ack_d     = src_ack_q;
    overrun_d     = overrun_q;
    glitch_d      = glitch_q;
    glitch_inc_s  = 1'b0;
    overrun_set_s = 1'b0;

    // Each edge of the synchronised request is one transfer.
    ev_s = req_s2_q ^ req_s3_q;

    case (state_q)
      ST_IDLE: begin
        if (ev_s || pending_q) begin
          sample_d = src_d;
          cnt_d    = 4'd1;
          // Consuming a queued request while a new one arrives re-queues the new one.
          pending_d = pending_q & ev_s;
          if (STABLE_CYCLES == 1) begin
            state_d = ST_LOAD;
            d_d     = src_d;
            ld_d    = 1'b1;
          end else begin
            state_d = ST_SAMPLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SAMPLE: begin
        if (src_d == sample_q) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_LOAD;
            d_d     = sample_q;
            ld_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          // Data moved: restart the stability window on the new value.
          sample_d     = src_d;
          cnt_d        = 4'd1;
          glitch_inc_s = 1'b1;
        end
      end
      ST_LOAD: begin
        state_d   = ST_IDLE;
        src_ack_d = ~src_ack_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Requests arriving while a transfer is in flight are queued one deep.
    if (ev_s && (state_q != ST_IDLE)) begin
      if (pending_q) begin
        overrun_set_s = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end else begin
      overrun_set_s = 1'b0;
    end

    // Clear has priority over both error indicators.
    if (clr) begin
      overrun_d = 1'b0;
      glitch_d  = 4'd0;
    end else begin
      if (overrun_set_s) begin
        overrun_d = 1'b1;
      end else begin
        overrun_d = overrun_q;
      end
      if (glitch_inc_s && (glitch_q != 4'd15)) begin
        glitch_d = glitch_q + 4'd1;
      end else begin
        glitch_d = glitch_q;
      end
    end

    busy_d = (state_d != ST_IDLE) | pending_d;
  end

  // State and output registers; reset aborts any transfer in progress.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      state_q   <= ST_IDLE;
      req_s1_q  <= 1'b0;
      req_s2_q  <= 1'b0;
      req_s3_q  <= 1'b0;
      pending_q <= 1'b0;
      sample_q  <= 6'd0;
      cnt_q     <= 4'd0;
      d_q       <= 6'd0;
      ld_q      <= 1'b0;
      src_ack_q <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      glitch_q  <= 4'd0;
    end else begin
      state_q   <= state_d;
      req_s1_q  <= req_s1_d;
      req_s2_q  <= req_s2_d;
      req_s3_q  <= req_s3_d;
      pending_q <= pending_d;
      sample_q  <= sample_d;
      cnt_q     <= cnt_d;
      d_q       <= d_d;
      ld_q      <= ld_d;
      src_ack_q <= src_ack_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      glitch_q  <= glitch_d;
    end
  end

  assign src_ack = src_ack_q;
  assign d       = d_q;
  assign ld      = ld_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;
  assign glitch  = glitch_q;

endmodule
